// File: rtl/i2c_target_acq_packer_pkg.sv
// rtl/i2c_target_acq_packer_pkg.sv - shared types and helpers for the I2C target ACQ packer
package i2c_target_acq_packer_pkg;

  localparam int AcqFifoWidth = 10;

  typedef enum logic [1:0] {
    ACQ_DATA    = 2'b00,
    ACQ_START   = 2'b01,
    ACQ_STOP    = 2'b10,
    ACQ_RESTART = 2'b11
  } acq_signal_e;

  typedef struct packed {
    logic [3:0]  reserved;
    logic        truncated;
    logic [2:0]  idx;
    logic        rw;
    logic [6:0]  addr;
    logic [15:0] count;
  } i2c_rx_desc_t;

  // A slot with an all-zero mask is disabled rather than matching everything.
  function automatic logic addr_hit(input logic [6:0] addr, input logic [6:0] target,
                                    input logic [6:0] mask);
    return (mask != 7'd0) && (((addr ^ target) & mask) == 7'd0);
  endfunction

endpackage

// File: rtl/i2c_target_acq_packer_addr_match.sv
// rtl/i2c_target_acq_packer_addr_match.sv - priority address/mask matcher, lowest slot wins
module i2c_target_acq_packer_addr_match
  import i2c_target_acq_packer_pkg::*;
#(
  parameter int NumAddr = 2
) (
  input  logic [6:0]              addr,
  input  logic [NumAddr-1:0][6:0] target_address,
  input  logic [NumAddr-1:0][6:0] target_mask,
  output logic                    match,
  output logic [2:0]              idx
);

  // Walk from the top slot down so the lowest matching index is the last writer.
  always_comb begin
    match = 1'b0;
    idx   = 3'd0;
    for (int i = NumAddr - 1; i >= 0; i--) begin
      if (addr_hit(addr, target_address[i], target_mask[i])) begin
        match = 1'b1;
        idx   = 3'(i);
      end
    end
  end

endmodule

// File: rtl/i2c_target_acq_packer.sv
// rtl/i2c_target_acq_packer.sv - filters ACQ transfers by address and packs write bytes into RX words + descriptors
module i2c_target_acq_packer #(
  parameter int NumAddr      = 2,
  parameter int RxDataWidth  = 32,
  parameter int RxDescWidth  = 32,
  parameter int AcqFifoWidth = i2c_target_acq_packer_pkg::AcqFifoWidth
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    enable_i,
  input  logic [NumAddr-1:0][6:0] target_address_i,
  input  logic [NumAddr-1:0][6:0] target_mask_i,
  input  logic                    acq_valid_i,
  input  logic [AcqFifoWidth-1:0] acq_data_i,
  output logic                    acq_ready_o,
  output logic                    rx_wvalid_o,
  input  logic                    rx_wready_i,
  output logic [RxDataWidth-1:0]  rx_wdata_o,
  output logic                    rx_desc_wvalid_o,
  input  logic                    rx_desc_wready_i,
  output logic [RxDescWidth-1:0]  rx_desc_wdata_o,
  output logic                    overflow_o,
  output logic                    busy_o
);
  import i2c_target_acq_packer_pkg::acq_signal_e;
  import i2c_target_acq_packer_pkg::ACQ_DATA;
  import i2c_target_acq_packer_pkg::ACQ_START;
  import i2c_target_acq_packer_pkg::ACQ_STOP;
  import i2c_target_acq_packer_pkg::ACQ_RESTART;
  import i2c_target_acq_packer_pkg::i2c_rx_desc_t;

  localparam int NumLanes = RxDataWidth / 8;
  localparam int LaneW    = (NumLanes > 1) ? $clog2(NumLanes) : 1;
  localparam logic [LaneW-1:0] LastLane = LaneW'(NumLanes - 1);

  typedef enum logic [2:0] {IDLE, SKIP, XFER, FLUSH, DESC} state_e;

  state_e                 state;
  logic [6:0]             addr;
  logic                   rw;
  logic [2:0]             idx;
  logic [15:0]            count;
  logic                   truncated;
  logic [LaneW-1:0]       lane;
  logic [RxDataWidth-1:0] acc;
  logic                   pend_restart;
  logic [7:0]             pend_byte;

  acq_signal_e            sig;
  logic [7:0]             acq_byte;
  logic                   is_start;
  logic                   word_stall;
  logic                   word_done;
  logic                   desc_done;
  logic [7:0]             start_byte;
  logic                   do_start;
  logic                   match;
  logic [2:0]             match_idx;
  logic [RxDataWidth-1:0] acc_ins;
  i2c_rx_desc_t           desc;
  logic [RxDescWidth-1:0] desc_ext;

  assign sig        = acq_signal_e'(acq_data_i[9:8]);
  assign acq_byte   = acq_data_i[7:0];
  assign is_start   = (sig == ACQ_START) || (sig == ACQ_RESTART);
  assign word_stall = rx_wvalid_o & ~rx_wready_i;
  assign word_done  = rx_wvalid_o & rx_wready_i;
  assign desc_done  = rx_desc_wvalid_o & rx_desc_wready_i;
  assign busy_o     = (state != IDLE);

  // A RESTART that ended a transfer is re-evaluated from its latched copy once the descriptor drains.
  assign start_byte = (state == DESC) ? pend_byte : acq_byte;

  i2c_target_acq_packer_addr_match #(
    .NumAddr (NumAddr)
  ) u_addr_match (
    .addr           (start_byte[7:1]),
    .target_address (target_address_i),
    .target_mask    (target_mask_i),
    .match          (match),
    .idx            (match_idx)
  );

  always_comb begin
    acc_ins = acc;
    acc_ins[{lane, 3'b000} +: 8] = acq_byte;
  end

  always_comb begin
    desc           = '0;
    desc.count     = count;
    desc.addr      = addr;
    desc.rw        = rw;
    desc.idx       = idx;
    desc.truncated = truncated;
    desc_ext       = '0;
    desc_ext[31:0] = desc;
  end

  always_comb begin
    do_start = 1'b0;
    if (enable_i) begin
      if ((state == IDLE || state == SKIP) && acq_valid_i && is_start) do_start = 1'b1;
      if (state == DESC && desc_done && pend_restart) do_start = 1'b1;
    end
  end

  // End-of-transfer entries stay in the ACQ queue until their descriptor is taken.
  always_comb begin
    acq_ready_o = 1'b0;
    if (!enable_i) begin
      acq_ready_o = 1'b1;
    end else begin
      case (state)
        IDLE, SKIP: acq_ready_o = 1'b1;
        XFER:       acq_ready_o = ~word_stall & ~(acq_valid_i & (sig != ACQ_DATA));
        DESC:       acq_ready_o = desc_done;
        default:    acq_ready_o = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state            <= IDLE;
      addr             <= '0;
      rw               <= 1'b0;
      idx              <= '0;
      count            <= '0;
      truncated        <= 1'b0;
      lane             <= '0;
      acc              <= '0;
      pend_restart     <= 1'b0;
      pend_byte        <= '0;
      rx_wvalid_o      <= 1'b0;
      rx_wdata_o       <= '0;
      rx_desc_wvalid_o <= 1'b0;
      rx_desc_wdata_o  <= '0;
      overflow_o       <= 1'b0;
    end else begin
      overflow_o <= 1'b0;
      if (word_done) rx_wvalid_o <= 1'b0;
      if (!enable_i) begin
        state            <= IDLE;
        rx_wvalid_o      <= 1'b0;
        rx_desc_wvalid_o <= 1'b0;
        lane             <= '0;
        acc              <= '0;
        count            <= '0;
      end else begin
        case (state)
          IDLE, SKIP: begin
            if (acq_valid_i && sig == ACQ_STOP) state <= IDLE;
          end
          XFER: begin
            if (acq_valid_i && !word_stall) begin
              if (sig == ACQ_DATA) begin
                if (!rw) begin
                  if (count == 16'hFFFF) begin
                    truncated  <= 1'b1;
                    overflow_o <= 1'b1;
                  end else begin
                    count <= count + 16'd1;
                    if (lane == LastLane) begin
                      rx_wdata_o  <= acc_ins;
                      rx_wvalid_o <= 1'b1;
                      acc         <= '0;
                      lane        <= '0;
                    end else begin
                      acc  <= acc_ins;
                      lane <= lane + LaneW'(1);
                    end
                  end
                end
              end else begin
                pend_restart <= (sig != ACQ_STOP);
                pend_byte    <= acq_byte;
                if (lane != '0) begin
                  rx_wdata_o  <= acc;
                  rx_wvalid_o <= 1'b1;
                  acc         <= '0;
                  lane        <= '0;
                  state       <= FLUSH;
                end else begin
                  rx_desc_wdata_o  <= desc_ext;
                  rx_desc_wvalid_o <= 1'b1;
                  state            <= DESC;
                end
              end
            end
          end
          FLUSH: begin
            if (word_done) begin
              rx_desc_wdata_o  <= desc_ext;
              rx_desc_wvalid_o <= 1'b1;
              state            <= DESC;
            end
          end
          DESC: begin
            if (desc_done) begin
              rx_desc_wvalid_o <= 1'b0;
              if (!pend_restart) state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase

        if (do_start) begin
          if (match) begin
            addr      <= start_byte[7:1];
            rw        <= start_byte[0];
            idx       <= match_idx;
            count     <= '0;
            truncated <= 1'b0;
            lane      <= '0;
            acc       <= '0;
            state     <= XFER;
          end else begin
            state <= SKIP;
          end
        end
      end
    end
  end

endmodule
